calc2_req_port: RTL
===================

# calc2_req_port

Requester-side port driver for the calc2 multiport ALU. It sits between a host command source and one of calc2's four request/response port pairs (reqN_cmd_in/data_in/tag_in, out_respN/dataN/tagN). Its jobs:
- serialise host operations into the calc2 two-cycle request protocol;
- allocate and recycle the four 2-bit tags;
- capture out-of-order responses into a 4-entry buffer drained by the host with a valid/ready handshake.

## Interface
- No parameters. Tag space fixed at 4, response buffer depth fixed at 4.
- c_clk  in  1  functional clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- host_valid  in  1  host operation present
- host_ready  out  1  block accepts the operation this cycle
- host_cmd  in  [0:3]  calc2 command: 0001 add, 0010 sub, 0101 shl, 0110 shr; other non-zero codes are passed through unchanged
- host_op1  in  [0:31]  operand 1
- host_op2  in  [0:31]  operand 2
- host_tag  out  [0:1]  tag allocated to the operation accepted this cycle
- req_cmd_out  out  [0:3]  to calc2 reqN_cmd_in
- req_data_out  out  [0:31]  to calc2 reqN_data_in
- req_tag_out  out  [0:1]  to calc2 reqN_tag_in
- out_resp  in  [0:1]  from calc2: 00 none, 01 success, 10 overflow/underflow/invalid, 11 internal error
- out_data  in  [0:31]  from calc2 result
- out_tag  in  [0:1]  from calc2 response tag
- rsp_valid  out  1  response buffer non-empty
- rsp_ready  in  1  host pops the head entry
- rsp_resp  out  [0:1]  head entry response code
- rsp_data  out  [0:31]  head entry data
- rsp_tag  out  [0:1]  head entry tag
- outstanding  out  [0:2]  busy tag count, 0..4
- err_stray  out  1  sticky; set by a response whose tag is not busy

## Operation
- **Issue FSM** states: IDLE, CMD, DATA2. All req_* outputs are registered.
  - IDLE: an accept (host_valid && host_ready at the edge) → CMD. Outputs become req_cmd_out=host_cmd, req_tag_out=allocated tag, req_data_out=host_op1.
  - CMD → DATA2 unconditionally. Outputs become req_cmd_out=0000, req_tag_out=00, req_data_out=op2 latched at accept.
  - DATA2: an accept → CMD, else → IDLE. In IDLE, req_cmd_out=0000, req_data_out=0, req_tag_out=00.
- **host_ready** = (state != CMD) && (at least one free tag) && !reset. It is combinational from registered state only and never depends on host_valid.
- **host_cmd=0000:** accepted and dropped. No tag consumed, FSM does not change state.
- **Tag allocation:** host_tag is the lowest-numbered free tag. That tag is marked busy at the accept edge.
- **Tag free:** a tag is freed at the edge where its entry is popped (rsp_valid && rsp_ready). A tag freed at an edge is allocatable from the next cycle on. Pop and accept on the same edge are both honoured.
- **Response capture:** every cycle with out_resp != 00:
  - out_tag busy and not already captured → push {out_resp, out_data, out_tag};
  - otherwise → set err_stray and push nothing.
- **Buffer bounds:** at most 4 tags are busy, so the buffer cannot overflow; no full flag is exposed. Push and pop on the same edge keep the count unchanged. Buffer order is arrival order, not tag order.
- **outstanding** = number of busy tags. It counts up on accept and down on pop, and holds when both occur on the same edge.

## Timing
- **Reset values:**
  - host_ready 0 while reset asserted;
  - host_tag 00, req_cmd_out 0000, req_data_out 0, req_tag_out 00;
  - rsp_valid 0, rsp_resp 00, rsp_data 0, rsp_tag 00;
  - outstanding 000, err_stray 0;
  - FSM IDLE, all tags free, buffer empty.
- **Accept at edge N:** cmd/op1/tag on req_* during cycle N+1, op2 during cycle N+2. The next command can appear in cycle N+3. Peak rate is one operation per 2 cycles.
- **Response:** one sampled at edge M gives rsp_valid=1 in cycle M+1 if the buffer was empty.
- **Reset mid-operation:** in-flight requests are abandoned. Responses arriving after reset deasserts carry non-busy tags and set err_stray.

## Test plan
- **Single add:** after reset, host add 0001, op1=0x00000005, op2=0x00000003. Expect host_tag=00; next cycle req_cmd_out=0001, data=0x5, tag=00; following cycle cmd=0000, data=0x3. Drive out_resp=01, out_data=0x8, out_tag=00. Expect rsp_valid next cycle with 01/0x8/00; outstanding goes 1→0 on pop.
- **Tag exhaustion:** issue 4 ops with rsp_ready=0. Expect tags 00,01,10,11 and host_ready=0 with outstanding=4. Pop tag 10 → the next accept gets tag 10.
- **Out-of-order responses:** responses with tags 11,00,10,01 arrive on consecutive cycles. Expect the buffer to drain in that same order; no err_stray.
- **Stray response:** out_resp=01, out_tag=01 with no busy tags. Expect err_stray=1 (sticky), rsp_valid stays 0.
- **Back-to-back and same-edge events:** host_valid held high for two ops. Expect the second accept in DATA2 and req_cmd_out non-zero in cycles 1 and 3. Separately, push and pop on the same edge → count unchanged.
- **Reset mid-flight:** assert reset during DATA2 with 2 tags busy. Expect all outputs at reset values immediately. A late response for tag 00 after reset sets err_stray.

Source files
------------

// File: rtl/calc2_req_port.sv
// Requester-side driver for one calc2 port: serialises host ops into the two-cycle
// request protocol, manages the 4 tags and buffers out-of-order responses.
module calc2_req_port (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [0:3]  host_cmd,
  input  logic [0:31] host_op1,
  input  logic [0:31] host_op2,
  output logic [0:1]  host_tag,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  output logic [0:1]  req_tag_out,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data,
  input  logic [0:1]  out_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:1]  rsp_resp,
  output logic [0:31] rsp_data,
  output logic [0:1]  rsp_tag,
  output logic [0:2]  outstanding,
  output logic        err_stray
);

  localparam int unsigned NUM_TAGS = 4;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PTR_W    = 2;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA2} state_e;

  typedef struct packed {
    logic [0:1]  resp;
    logic [0:31] data;
    logic [0:1]  tag;
  } rsp_ent_t;

  state_e               state_q, state_d;
  logic [0:3]           req_cmd_q, req_cmd_d;
  logic [0:31]          req_data_q, req_data_d;
  logic [0:1]           req_tag_q, req_tag_d;
  logic [0:31]          op2_q, op2_d;
  logic [NUM_TAGS-1:0]  busy_q, busy_d;
  logic [NUM_TAGS-1:0]  cap_q, cap_d;
  logic [CNT_W-1:0]     outst_q, outst_d;
  logic                 err_q, err_d;
  rsp_ent_t             mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 free_any;
  logic                 found;
  logic [0:1]           alloc;
  logic                 accept;
  logic                 pop;
  logic                 push;
  logic                 rsp_seen;
  rsp_ent_t             head;

  // Lowest-numbered free tag; don't-care (00) when none is free.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (!busy_q[i] && !found) begin
        alloc = 2'(i);
        found = 1'b1;
      end
    end
  end

  assign free_any   = (busy_q != '1);
  assign host_ready = (state_q != S_CMD) && free_any && !reset;
  assign host_tag   = alloc;
  // A zero command is taken off the host but never reaches calc2.
  assign accept     = host_valid && host_ready && (host_cmd != 4'b0000);

  assign head      = mem_q[rd_ptr_q];
  assign pop       = (cnt_q != '0) && rsp_ready;
  assign rsp_seen  = (out_resp != 2'b00);
  assign push      = rsp_seen && busy_q[out_tag] && !cap_q[out_tag];

  // Issue FSM: next state and next request outputs.
  always_comb begin
    state_d    = state_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    req_tag_d  = '0;
    op2_d      = op2_q;
    case (state_q)
      S_CMD: begin
        state_d    = S_DATA2;
        req_data_d = op2_q;
      end
      default: begin
        if (accept) begin
          state_d    = S_CMD;
          req_cmd_d  = host_cmd;
          req_tag_d  = alloc;
          req_data_d = host_op1;
          op2_d      = host_op2;
        end else begin
          state_d    = S_IDLE;
        end
      end
    endcase
  end

  // Tag bookkeeping, busy count and stray-response flag.
  always_comb begin
    busy_d  = busy_q;
    cap_d   = cap_q;
    outst_d = outst_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (pop) begin
      busy_d[head.tag] = 1'b0;
      cap_d[head.tag]  = 1'b0;
    end
    if (accept) begin
      busy_d[alloc] = 1'b1;
    end
    if (push) begin
      cap_d[out_tag] = 1'b1;
    end
    if (rsp_seen && !push) begin
      err_d = 1'b1;
    end
    if (accept && !pop) begin
      outst_d = CNT_W'(outst_q + 1'b1);
    end else if (pop && !accept) begin
      outst_d = CNT_W'(outst_q - 1'b1);
    end
    if (push && !pop) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end else if (pop && !push) begin
      cnt_d = CNT_W'(cnt_q - 1'b1);
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_cmd_q  <= '0;
      req_data_q <= '0;
      req_tag_q  <= '0;
      op2_q      <= '0;
      busy_q     <= '0;
      cap_q      <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_cmd_q  <= req_cmd_d;
      req_data_q <= req_data_d;
      req_tag_q  <= req_tag_d;
      op2_q      <= op2_d;
      busy_q     <= busy_d;
      cap_q      <= cap_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{resp: out_resp, data: out_data, tag: out_tag};
        wr_ptr_q        <= PTR_W'(wr_ptr_q + 1'b1);
      end
      if (pop) begin
        rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
      end
    end
  end

  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign req_tag_out  = req_tag_q;
  assign rsp_valid    = (cnt_q != '0);
  assign rsp_resp     = head.resp;
  assign rsp_data     = head.data;
  assign rsp_tag      = head.tag;
  assign outstanding  = outst_q;
  assign err_stray    = err_q;

endmodule
